// File: rtl/io_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// io_write_buffer_pkg
// Shared bus parameters for the memory-mapped I/O write buffer: CPU word
// width, byte width, the decoded address width and the two I/O addresses.
// Also provides the bus-cycle decoder used by io_write_buffer.
// -----------------------------------------------------------------------------
package io_write_buffer_pkg;

    localparam int XLEN     = 32;   // CPU address width
    localparam int BYTE_W   = 8;    // width of one I/O data byte
    localparam int DECODE_W = 18;   // only cpu_a[17:0] is decoded

    localparam logic [DECODE_W-1:0] IO_DATA_ADDR_DFLT = 18'h30000;
    localparam logic [DECODE_W-1:0] IO_HALT_ADDR_DFLT = 18'h30004;

    // Classification of one CPU bus cycle as seen by the buffer.
    typedef enum logic [1:0] {
        BUS_IGNORE = 2'd0,  // idle, read, paused CPU or ordinary RAM traffic
        BUS_DATA   = 2'd1,  // byte write to the UART data address
        BUS_HALT   = 2'd2   // program-halt request
    } bus_op_e;

    function automatic bus_op_e decode_bus(
        input logic                rdy,
        input logic                wr,
        input logic [DECODE_W-1:0] addr,
        input logic [DECODE_W-1:0] data_addr,
        input logic [DECODE_W-1:0] halt_addr
    );
        decode_bus = BUS_IGNORE;
        if (rdy && wr) begin
            if (addr == data_addr) begin
                decode_bus = BUS_DATA;
            end else if (addr == halt_addr) begin
                decode_bus = BUS_HALT;
            end
        end
    endfunction

endpackage

// File: rtl/io_write_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// io_write_buffer_sync_fifo
// Single-clock FIFO, 2**DEPTH_WIDTH entries of WIDTH bits. Head data is shown
// straight from the storage array, so the reader sees a byte the cycle after
// it was pushed into an empty FIFO.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset (pointers and count only)
//   push_i        write data_i at tail; accepted when not full, or when a pop
//                 happens in the same cycle
//   pop_i         drop the head entry; ignored when empty
//   data_i        write data
//   data_o        head entry, 0 while empty
//   count_o       current occupancy
//   count_next_o  occupancy after this cycle's push/pop
//   empty_o       count_o == 0
//   full_o        count_o == depth
// -----------------------------------------------------------------------------
module io_write_buffer_sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [DEPTH_WIDTH:0]   count_o,
    output logic [DEPTH_WIDTH:0]   count_next_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int                 DEPTH     = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] head_q, head_d;
    logic [DEPTH_WIDTH-1:0] tail_q, tail_d;
    logic [DEPTH_WIDTH:0]   count_q, count_d;
    logic                   do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);

    // A push into a full FIFO is legal when the head leaves in the same cycle:
    // the slot being written is the one being vacated.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + 1'b1;   // wraps naturally at DEPTH
        end
        if (do_push) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every
    // read, so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= data_i;
        end
    end

    assign data_o       = empty_o ? '0 : mem_q[head_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/io_write_buffer.sv
// -----------------------------------------------------------------------------
// io_write_buffer
// Sits on the CPU memory bus beside RAM. Byte writes to IO_DATA_ADDR are queued
// in a FIFO that drains to the UART transmitter over valid/ready; a write to
// IO_HALT_ADDR raises halt once every queued byte has left.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   rdy_in          CPU bus is only sampled while high
//   cpu_dout        CPU write data
//   cpu_a           CPU address, bits [17:0] decoded
//   cpu_wr          CPU write strobe
//   tx_ready        transmitter takes the head byte this cycle
//   tx_valid        head byte valid (registered state only)
//   tx_data         head byte
//   io_buffer_full  back-pressure to the CPU, registered
//   overflow        sticky: a byte was dropped on a full FIFO
//   halt            sticky: halt requested and FIFO drained
//
// Build option: define IO_BUF_STATS_EN to add the tx_count (bytes sent) and
// full_cycles (cycles with io_buffer_full high) 32-bit wrapping counters.
// -----------------------------------------------------------------------------
module io_write_buffer
    import io_write_buffer_pkg::*;
#(
    parameter int                  DEPTH_WIDTH  = 4,
    parameter int                  FULL_MARGIN  = 2,
    parameter logic [DECODE_W-1:0] IO_DATA_ADDR = IO_DATA_ADDR_DFLT,
    parameter logic [DECODE_W-1:0] IO_HALT_ADDR = IO_HALT_ADDR_DFLT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [BYTE_W-1:0] cpu_dout,
    input  logic [XLEN-1:0]   cpu_a,
    input  logic              cpu_wr,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              io_buffer_full,
    output logic              overflow,
    output logic              halt
`ifdef IO_BUF_STATS_EN
    ,
    output logic [31:0]       tx_count,
    output logic [31:0]       full_cycles
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    // Threshold leaves FULL_MARGIN slots for writes the CPU has already
    // committed before it sees back-pressure.
    localparam logic [DEPTH_WIDTH:0] FULL_THRESH = (DEPTH_WIDTH + 1)'(DEPTH - FULL_MARGIN);

    bus_op_e              bus_op;
    logic                 push_req, halt_req, pop;
    logic [DEPTH_WIDTH:0] count, count_next;
    logic                 fifo_empty, fifo_full;
    logic                 unused_addr_bits;

    logic overflow_q, overflow_d;
    logic halt_pending_q, halt_pending_d;
    logic halt_q, halt_d;
    logic full_q, full_d;

    assign bus_op   = decode_bus(rdy_in, cpu_wr, cpu_a[DECODE_W-1:0], IO_DATA_ADDR, IO_HALT_ADDR);
    assign push_req = (bus_op == BUS_DATA);
    assign halt_req = (bus_op == BUS_HALT);
    assign unused_addr_bits = ^cpu_a[XLEN-1:DECODE_W];

    // Draining does not depend on rdy_in: the UART keeps going while the CPU
    // is stalled.
    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready;

    io_write_buffer_sync_fifo #(
        .WIDTH       (BYTE_W),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .push_i       (push_req),
        .pop_i        (pop),
        .data_i       (cpu_dout),
        .data_o       (tx_data),
        .count_o      (count),
        .count_next_o (count_next),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    always_comb begin
        overflow_d     = overflow_q | (push_req && fifo_full && !pop);
        halt_pending_d = halt_pending_q | halt_req;
        // A push in the same cycle means the FIFO is not really drained yet.
        halt_d         = halt_q | (halt_pending_q && (count == '0) && !push_req);
        full_d         = (count_next >= FULL_THRESH);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overflow_q     <= 1'b0;
            halt_pending_q <= 1'b0;
            halt_q         <= 1'b0;
            full_q         <= 1'b0;
        end else begin
            overflow_q     <= overflow_d;
            halt_pending_q <= halt_pending_d;
            halt_q         <= halt_d;
            full_q         <= full_d;
        end
    end

    assign io_buffer_full = full_q;
    assign overflow       = overflow_q;
    assign halt           = halt_q;

`ifdef IO_BUF_STATS_EN
    logic [31:0] tx_count_q, full_cycles_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_count_q    <= '0;
            full_cycles_q <= '0;
        end else begin
            if (pop) begin
                tx_count_q <= tx_count_q + 32'd1;
            end
            if (full_q) begin
                full_cycles_q <= full_cycles_q + 32'd1;
            end
        end
    end

    assign tx_count    = tx_count_q;
    assign full_cycles = full_cycles_q;
`endif

endmodule

// File: tb/tb_io_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_io_write_buffer
// Self-checking bench for io_write_buffer. A queue-based model tracks what the
// buffer must hold and show; a compare process checks the DUT against it on
// every falling edge, and directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_io_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy, wr, txr;
    logic [7:0]  dout;
    logic [31:0] a;
    logic        tx_valid, io_buffer_full, overflow, halt;
    logic [7:0]  tx_data;
`ifdef IO_BUF_STATS_EN
    logic [31:0] tx_count, full_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_write_buffer dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .cpu_dout       (dout),
        .cpu_a          (a),
        .cpu_wr         (wr),
        .tx_ready       (txr),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .io_buffer_full (io_buffer_full),
        .overflow       (overflow),
        .halt           (halt)
`ifdef IO_BUF_STATS_EN
        ,
        .tx_count       (tx_count),
        .full_cycles    (full_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         m_ovf, m_hp, m_halt, m_full;
    int         m_pops, m_fc;

    always @(posedge clk or posedge rst) begin : model_upd
        bit is_push, is_halt_wr, is_pop;
        int pre;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_hp = 0; m_halt = 0; m_full = 0;
            m_pops = 0; m_fc = 0;
        end else begin
            is_push    = rdy && wr && (a[17:0] == 18'h30000);
            is_halt_wr = rdy && wr && (a[17:0] == 18'h30004);
            pre        = mq.size();
            is_pop     = (pre != 0) && txr;
            if (m_full) m_fc++;
            if (m_hp && pre == 0 && !is_push) m_halt = 1;
            if (is_pop) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (is_push) begin
                if (pre < 16 || is_pop) mq.push_back(dout);
                else m_ovf = 1;
            end
            if (is_halt_wr) m_hp = 1;
            m_full = (mq.size() >= 14);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_tx_valid", tx_valid, (mq.size() != 0));
            if (mq.size() != 0) check("cmp_tx_data", tx_data, mq[0]);
            check("cmp_full", io_buffer_full, m_full);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_halt", halt, m_halt);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] seen[$];

    task automatic cyc(input logic r, input logic w, input logic [31:0] addr,
                       input logic [7:0] d, input logic t);
        rdy = r; wr = w; a = addr; dout = d; txr = t;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic t);
        cyc(1'b1, 1'b1, 32'h0003_0000, d, t);
    endtask

    task automatic idle(input logic t);
        cyc(1'b1, 1'b0, 32'h0, 8'h00, t);
    endtask

    // Records head bytes while draining; bounded so a stuck tx_valid fails.
    task automatic drain(input int max_cycles);
        int n = 0;
        while (tx_valid === 1'b1 && n < max_cycles) begin
            seen.push_back(tx_data);
            idle(1'b1);
            n++;
        end
        check("drain_empty", tx_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; rdy = 1'b0; wr = 1'b0; a = '0; dout = '0; txr = 1'b0;
        #3;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_full", io_buffer_full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_halt", halt, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single byte: visible for exactly one cycle.
        push(8'h41, 1'b1);
        check("single_valid", tx_valid, 1'b1);
        check("single_data", tx_data, 8'h41);
        idle(1'b1);
        check("single_gone", tx_valid, 1'b0);

        // Threshold, pushing through an alias address (upper bits ignored).
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 32'hABC3_0000, 8'(i), 1'b0);
        check("thr_13_full", io_buffer_full, 1'b0);
        cyc(1'b1, 1'b1, 32'hABC3_0000, 8'd13, 1'b0);
        check("thr_14_full", io_buffer_full, 1'b1);
        idle(1'b1);
        check("thr_pop_full", io_buffer_full, 1'b0);
        seen.delete();
        drain(40);
        check("thr_drain_n", seen.size(), 13);

        // Overflow: 17th byte dropped, order 0..15.
        for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_full", io_buffer_full, 1'b1);
        seen.delete();
        drain(40);
        check("ovf_drain_n", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) check("ovf_order", seen[i], i);

        // Clear sticky overflow before the wrap test.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Wrap: 20 bytes streaming through at one per cycle.
        seen.delete();
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) seen.push_back(tx_data);
            push(8'(8'h80 + i), 1'b1);
        end
        drain(40);
        check("wrap_n", seen.size(), 20);
        for (int i = 0; i < 20 && i < seen.size(); i++) check("wrap_order", seen[i], 8'h80 + i);
        check("wrap_no_ovf", overflow, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
        check("fpp_full_pre", io_buffer_full, 1'b1);
        push(8'hAA, 1'b1);
        check("fpp_no_ovf", overflow, 1'b0);
        check("fpp_full_post", io_buffer_full, 1'b1);
        seen.delete();
        drain(40);
        check("fpp_n", seen.size(), 16);
        if (seen.size() == 16) begin
            check("fpp_first", seen[0], 8'h11);
            check("fpp_last", seen[15], 8'hAA);
        end

        // Halt after drain; RAM write to 0x20000 ignored.
        for (int i = 1; i <= 3; i++) push(8'(i), 1'b0);
        cyc(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 32'h0002_0000, 8'h55, 1'b0);
        check("halt_pre", halt, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("halt_draining", halt, 1'b0);
        end
        check("halt_empty", tx_valid, 1'b0);
        idle(1'b1);
        check("halt_set", halt, 1'b1);
        push(8'h66, 1'b0);
        check("halt_sticky", halt, 1'b1);
        check("halt_push_valid", tx_valid, 1'b1);

        // rdy_in low: bus ignored, draining continues.
        cyc(1'b0, 1'b1, 32'h0003_0000, 8'h77, 1'b1);
        check("rdy_drained", tx_valid, 1'b0);
        cyc(1'b0, 1'b1, 32'h0003_0000, 8'h78, 1'b0);
        check("rdy_ignored", tx_valid, 1'b0);

`ifdef IO_BUF_STATS_EN
        check("stats_tx_count", tx_count, m_pops);
        check("stats_full_cycles", full_cycles, m_fc);
`endif

        // Async reset mid-drain with full, overflow and halt all set.
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i), 1'b0);
        idle(1'b1);
        check("arst_pre_full", io_buffer_full, 1'b1);
        check("arst_pre_ovf", overflow, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_full", io_buffer_full, 1'b0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_halt", halt, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        push(8'h5A, 1'b1);
        check("post_rst_data", tx_data, 8'h5A);
        idle(1'b1);
        check("post_rst_empty", tx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
